npu_res_checker: RTL and testbench

Synthesizable, parametrised result checker for the NPU output stream, the next generation of the bench scoreboard.
- Accepts each datapath write beat (partial row, bank, address) and fetches the matching golden row from a synchronous-read golden memory.
- Compares lane by lane, counts beats and mismatching lanes, and captures the first failure.
- Sits beside `dp`/`fsm`: in simulation it replaces the behavioural scoreboard; on FPGA it gives self-checking runs with a readable pass/fail status.

---
 rtl/npu_chk_pkg.sv | 35 +++
 rtl/npu_chk_lane_cmp.sv | 53 +++++
 rtl/npu_res_checker.sv | 197 +++++++++++++++++++
 tb/tb_npu_res_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_chk_pkg.sv
// Shared types, default sizes and helpers for the npu_res_checker slice.
// Default lane geometry mirrors globals_sv (N=4, W=16, PARTS=2).
package npu_chk_pkg;

  localparam int N_DEF     = 4;
  localparam int W_DEF     = 16;
  localparam int PARTS_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int lpb_of(input int w, input int parts);
    return w / parts;
  endfunction

  function automatic int part_w_of(input int parts);
    return (parts > 1) ? $clog2(parts) : 1;
  endfunction

  localparam int LPB    = lpb_of(W_DEF, PARTS_DEF);
  localparam int PART_W = part_w_of(PARTS_DEF);

  // Clamp at max instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/npu_chk_lane_cmp.sv
// Combinational lane comparator: picks the golden slice for the beat's part,
// builds the mismatch mask, its popcount and the lowest mismatching lane.
module npu_chk_lane_cmp
  import npu_chk_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int W      = W_DEF,
  parameter int PARTS  = PARTS_DEF,
  parameter int LANES  = lpb_of(W, PARTS),
  parameter int PRT_W  = part_w_of(PARTS),
  parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
  parameter int POP_W  = $clog2(LANES + 1)
) (
  input  logic [N*LANES-1:0] data,
  input  logic [PRT_W-1:0]   part,
  input  logic [N*W-1:0]     gold,
  output logic               part_ok,
  output logic               any_err,
  output logic [POP_W-1:0]   pop,
  output logic [LANE_W-1:0]  first_lane
);

  logic [N*LANES-1:0] slice;
  logic [LANES-1:0]   mask;

  assign part_ok = (32'(part) < PARTS);

  // Lane 0 sits in the MSBs, so part p starts p*LANES lanes below the top.
  always_comb begin
    slice = '0;
    for (int p = 0; p < PARTS; p++) begin
      if (part == PRT_W'(p)) slice = gold[N*W-1-p*N*LANES -: N*LANES];
    end
  end

  always_comb begin
    mask       = '0;
    pop        = '0;
    first_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      mask[k] = part_ok && (data[N*LANES-1-k*N -: N] != slice[N*LANES-1-k*N -: N]);
    end
    for (int k = 0; k < LANES; k++) begin
      pop = pop + POP_W'(mask[k]);
    end
    for (int k = LANES - 1; k >= 0; k--) begin
      if (mask[k]) first_lane = LANE_W'(k);
    end
  end

  assign any_err = |mask;

endmodule

// File: rtl/npu_res_checker.sv
// Result checker for the NPU output stream: 3-stage compare pipeline against a
// synchronous golden memory. Optional halt-on-first-error: NPU_CHK_HALT_EN.
module npu_res_checker
  import npu_chk_pkg::*;
#(
  parameter int  N      = N_DEF,
  parameter int  W      = W_DEF,
  parameter int  PARTS  = PARTS_DEF,
  parameter int  ADDR_W = 14,
  parameter int  CNT_W  = 16,
  localparam int LANES  = lpb_of(W, PARTS),
  localparam int PRT_W  = part_w_of(PARTS),
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              i_wr,
  input  logic              i_bank,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [PRT_W-1:0]  i_part,
  input  logic [N*LANES-1:0] i_data,
  output logic              o_gold_rd,
  output logic              o_gold_bank,
  output logic [ADDR_W-1:0] o_gold_addr,
  input  logic [N*W-1:0]    i_gold_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [CNT_W-1:0]  o_beat_cnt,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic              o_ferr_valid,
  output logic              o_ferr_bank,
  output logic [ADDR_W-1:0] o_ferr_addr,
  output logic [PRT_W-1:0]  o_ferr_part,
  output logic [LANE_W-1:0] o_ferr_lane,
  output logic              o_halt,
  output state_t            o_state
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : 32'((64'd1 << CNT_W) - 64'd1);

  state_t state, state_nx;
  logic   drain_last;
  logic   acc, clr, cap, halt_set;

  logic               s0_valid, s0_bank;
  logic [ADDR_W-1:0]  s0_addr;
  logic [PRT_W-1:0]   s0_part;
  logic [N*LANES-1:0] s0_data;

  logic               cmp_ok, cmp_any;
  logic [POP_W-1:0]   cmp_pop;
  logic [LANE_W-1:0]  cmp_lane;

  logic               s1_valid, s1_any, s1_bank;
  logic [ADDR_W-1:0]  s1_addr;
  logic [PRT_W-1:0]   s1_part;
  logic [LANE_W-1:0]  s1_lane;
  logic [POP_W-1:0]   s1_add;

  // Handshake: a beat is taken whenever i_wr is high in RUN; there is no ready,
  // the checker always keeps up at one beat per cycle.
  assign acc         = i_wr && (state == ST_RUN);
  assign clr         = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign cap         = s1_valid && s1_any && !o_ferr_valid;
  assign o_gold_rd   = acc;
  assign o_gold_bank = i_bank;
  assign o_gold_addr = i_addr;
  assign o_busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign o_done      = (state == ST_DONE);
  assign o_pass      = (state == ST_DONE) && (o_err_cnt == '0);
  assign o_state     = state;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      drain_last <= 1'b0;
    end else begin
      state      <= state_nx;
      drain_last <= (state == ST_DRAIN);
    end
  end

  // DRAIN lasts two cycles, enough for the last accepted beat to reach the counters.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN:   if (stop || halt_set) state_nx = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_nx = ST_DONE;
      ST_DONE:  if (start) state_nx = ST_RUN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_bank  <= 1'b0;
      s0_addr  <= '0;
      s0_part  <= '0;
      s0_data  <= '0;
    end else begin
      s0_valid <= acc;
      if (acc) begin
        s0_bank <= i_bank;
        s0_addr <= i_addr;
        s0_part <= i_part;
        s0_data <= i_data;
      end
    end
  end

  npu_chk_lane_cmp #(
    .N(N), .W(W), .PARTS(PARTS), .LANES(LANES),
    .PRT_W(PRT_W), .LANE_W(LANE_W), .POP_W(POP_W)
  ) u_cmp (
    .data       (s0_data),
    .part       (s0_part),
    .gold       (i_gold_data),
    .part_ok    (cmp_ok),
    .any_err    (cmp_any),
    .pop        (cmp_pop),
    .first_lane (cmp_lane)
  );

  // An out-of-range part is not compared but charges every lane of the beat.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_any   <= 1'b0;
      s1_bank  <= 1'b0;
      s1_addr  <= '0;
      s1_part  <= '0;
      s1_lane  <= '0;
      s1_add   <= '0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_any  <= cmp_any;
        s1_bank <= s0_bank;
        s1_addr <= s0_addr;
        s1_part <= s0_part;
        s1_lane <= cmp_lane;
        s1_add  <= cmp_ok ? cmp_pop : POP_W'(LANES);
      end
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      o_beat_cnt   <= '0;
      o_err_cnt    <= '0;
      o_ferr_valid <= 1'b0;
      o_ferr_bank  <= 1'b0;
      o_ferr_addr  <= '0;
      o_ferr_part  <= '0;
      o_ferr_lane  <= '0;
    end else if (clr) begin
      o_beat_cnt   <= '0;
      o_err_cnt    <= '0;
      o_ferr_valid <= 1'b0;
      o_ferr_bank  <= 1'b0;
      o_ferr_addr  <= '0;
      o_ferr_part  <= '0;
      o_ferr_lane  <= '0;
    end else if (s1_valid) begin
      o_beat_cnt <= CNT_W'(sat_add(32'(o_beat_cnt), 32'd1, CNT_MAX));
      o_err_cnt  <= CNT_W'(sat_add(32'(o_err_cnt), 32'(s1_add), CNT_MAX));
      if (cap) begin
        o_ferr_valid <= 1'b1;
        o_ferr_bank  <= s1_bank;
        o_ferr_addr  <= s1_addr;
        o_ferr_part  <= s1_part;
        o_ferr_lane  <= s1_lane;
      end
    end
  end

`ifdef NPU_CHK_HALT_EN
  assign halt_set = cap;

  always_ff @(posedge ck or posedge rst) begin
    if (rst)           o_halt <= 1'b0;
    else if (clr)      o_halt <= 1'b0;
    else if (halt_set) o_halt <= 1'b1;
  end
`else
  assign halt_set = 1'b0;
  assign o_halt   = 1'b0;
`endif

endmodule

// File: tb/tb_npu_res_checker.sv
// Directed bench for npu_res_checker (N=4, W=16, PARTS=2) with a small
// two-bank golden memory model and immediate-assertion checks.
module tb_npu_res_checker;
  import npu_chk_pkg::*;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        i_wr = 1'b0;
  logic        i_bank = 1'b0;
  logic [13:0] i_addr = '0;
  logic [0:0]  i_part = '0;
  logic [31:0] i_data = '0;
  logic [63:0] i_gold_data = '0;
  logic        o_gold_rd, o_gold_bank;
  logic [13:0] o_gold_addr;
  logic        o_busy, o_done, o_pass;
  logic [15:0] o_beat_cnt, o_err_cnt;
  logic        o_ferr_valid, o_ferr_bank;
  logic [13:0] o_ferr_addr;
  logic [0:0]  o_ferr_part;
  logic [2:0]  o_ferr_lane;
  logic        o_halt;
  state_t      o_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] gmem [2][16];

  always #5 ck = ~ck;

  npu_res_checker #(
    .N(4), .W(16), .PARTS(2), .ADDR_W(14), .CNT_W(16)
  ) dut (
    .ck           (ck),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .i_wr         (i_wr),
    .i_bank       (i_bank),
    .i_addr       (i_addr),
    .i_part       (i_part),
    .i_data       (i_data),
    .o_gold_rd    (o_gold_rd),
    .o_gold_bank  (o_gold_bank),
    .o_gold_addr  (o_gold_addr),
    .i_gold_data  (i_gold_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_pass       (o_pass),
    .o_beat_cnt   (o_beat_cnt),
    .o_err_cnt    (o_err_cnt),
    .o_ferr_valid (o_ferr_valid),
    .o_ferr_bank  (o_ferr_bank),
    .o_ferr_addr  (o_ferr_addr),
    .o_ferr_part  (o_ferr_part),
    .o_ferr_lane  (o_ferr_lane),
    .o_halt       (o_halt),
    .o_state      (o_state)
  );

  // Synchronous-read golden memory: data valid the cycle after the strobe.
  always @(posedge ck) begin
    if (o_gold_rd) i_gold_data <= gmem[o_gold_bank][o_gold_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gold_part(input logic b, input logic [13:0] a, input logic p);
    logic [63:0] r;
    r = gmem[b][a[3:0]];
    return p ? r[31:0] : r[63:32];
  endfunction

  task automatic tick();
    @(negedge ck);
  endtask

  task automatic idle(input int n);
    i_wr = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_beat(input logic b, input logic [13:0] a, input logic p, input logic [31:0] flip);
    i_wr   = 1'b1;
    i_bank = b;
    i_addr = a;
    i_part = p;
    i_data = gold_part(b, a, p) ^ flip;
  endtask

  task automatic beat(input logic b, input logic [13:0] a, input logic p, input logic [31:0] flip);
    set_beat(b, a, p, flip);
    tick();
    i_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_layer(input string tag);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk({tag, "_drain1_done"}, 64'(o_done), 64'd0);
    tick();
    chk({tag, "_drain2_done"}, 64'(o_done), 64'd0);
    tick();
    chk({tag, "_done"}, 64'(o_done), 64'd1);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 64'(o_state), 64'(ST_IDLE));
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_pass"}, 64'(o_pass), 64'd0);
    chk({tag, "_gold_rd"}, 64'(o_gold_rd), 64'd0);
    chk({tag, "_beat_cnt"}, 64'(o_beat_cnt), 64'd0);
    chk({tag, "_err_cnt"}, 64'(o_err_cnt), 64'd0);
    chk({tag, "_ferr_valid"}, 64'(o_ferr_valid), 64'd0);
    chk({tag, "_ferr_bank"}, 64'(o_ferr_bank), 64'd0);
    chk({tag, "_ferr_addr"}, 64'(o_ferr_addr), 64'd0);
    chk({tag, "_ferr_part"}, 64'(o_ferr_part), 64'd0);
    chk({tag, "_ferr_lane"}, 64'(o_ferr_lane), 64'd0);
    chk({tag, "_halt"}, 64'(o_halt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] flip;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 16; a++)
        gmem[b][a] = 64'hFEDC_BA98_7654_3210 ^ {16{4'(a + 3 * b)}};
    gmem[1][5] = 64'h0123_4567_89AB_CDEF;

    // Reset state
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Four clean beats over rows 0..1
    pulse_start();
    chk("s1_state_run", 64'(o_state), 64'(ST_RUN));
    set_beat(1'b0, 14'd1, 1'b0, 32'h0);
    #1;
    chk("s1_gold_rd", 64'(o_gold_rd), 64'd1);
    chk("s1_gold_addr", 64'(o_gold_addr), 64'd1);
    tick();
    beat(1'b0, 14'd1, 1'b1, 32'h0);
    beat(1'b0, 14'd0, 1'b0, 32'h0);
    beat(1'b0, 14'd0, 1'b1, 32'h0);
    finish_layer("s1");
    chk("s1_beat_cnt", 64'(o_beat_cnt), 64'd4);
    chk("s1_err_cnt", 64'(o_err_cnt), 64'd0);
    chk("s1_pass", 64'(o_pass), 64'd1);
    chk("s1_ferr_valid", 64'(o_ferr_valid), 64'd0);

`ifdef NPU_CHK_HALT_EN
    // Error on beat 3 of 10, one beat every 4 cycles
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      flip = (i == 2) ? 32'h000F_0000 : 32'h0;
      beat(1'b0, 14'd6, i[0], flip);
      idle(3);
    end
    chk("halt_o_halt", 64'(o_halt), 64'd1);
    chk("halt_beat_cnt", 64'(o_beat_cnt), 64'd3);
    chk("halt_err_cnt", 64'(o_err_cnt), 64'd1);
    chk("halt_ferr_lane", 64'(o_ferr_lane), 64'd3);
    chk("halt_done", 64'(o_done), 64'd1);
    pulse_start();
    chk("halt_cleared", 64'(o_halt), 64'd0);
    chk("halt_cnt_cleared", 64'(o_beat_cnt), 64'd0);
    finish_layer("halt");
`else
    // Odd[5] part 1: 0x89ABCDEF vs 0x89AB0DEF, lane 4 differs
    pulse_start();
    chk("s2_cleared", 64'(o_beat_cnt), 64'd0);
    beat(1'b1, 14'd5, 1'b1, 32'h0000_C000);
    finish_layer("s2");
    chk("s2_beat_cnt", 64'(o_beat_cnt), 64'd1);
    chk("s2_err_cnt", 64'(o_err_cnt), 64'd1);
    chk("s2_ferr_valid", 64'(o_ferr_valid), 64'd1);
    chk("s2_ferr_bank", 64'(o_ferr_bank), 64'd1);
    chk("s2_ferr_addr", 64'(o_ferr_addr), 64'd5);
    chk("s2_ferr_part", 64'(o_ferr_part), 64'd1);
    chk("s2_ferr_lane", 64'(o_ferr_lane), 64'd4);
    chk("s2_pass", 64'(o_pass), 64'd0);
    chk("s2_halt", 64'(o_halt), 64'd0);

    // Lanes 2 and 7 wrong, then lane 0 wrong: 3 lanes total, capture lane 2
    pulse_start();
    beat(1'b0, 14'd2, 1'b0, 32'h00F0_000F);
    beat(1'b0, 14'd3, 1'b1, 32'hF000_0000);
    idle(3);
    pulse_start();
    chk("s3_start_ignored_err", 64'(o_err_cnt), 64'd3);
    chk("s3_start_ignored_busy", 64'(o_busy), 64'd1);
    finish_layer("s3");
    chk("s3_beat_cnt", 64'(o_beat_cnt), 64'd2);
    chk("s3_err_cnt", 64'(o_err_cnt), 64'd3);
    chk("s3_ferr_addr", 64'(o_ferr_addr), 64'd2);
    chk("s3_ferr_part", 64'(o_ferr_part), 64'd0);
    chk("s3_ferr_lane", 64'(o_ferr_lane), 64'd2);

    // Beat with stop is taken (lane 1 wrong); beat in DRAIN is ignored
    pulse_start();
    set_beat(1'b0, 14'd2, 1'b0, 32'h0F00_0000);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    set_beat(1'b0, 14'd3, 1'b0, 32'hFFFF_FFFF);
    #1;
    chk("s4_drain_gold_rd", 64'(o_gold_rd), 64'd0);
    tick();
    i_wr = 1'b0;
    chk("s4_drain2_done", 64'(o_done), 64'd0);
    tick();
    chk("s4_done", 64'(o_done), 64'd1);
    chk("s4_beat_cnt", 64'(o_beat_cnt), 64'd1);
    chk("s4_err_cnt", 64'(o_err_cnt), 64'd1);
    chk("s4_ferr_lane", 64'(o_ferr_lane), 64'd1);

    // Saturation: 8191 all-wrong beats = 0xFFF8, +6 = 0xFFFE, +8 clamps
    pulse_start();
    for (int i = 0; i < 8191; i++) beat(1'b0, 14'd0, i[0], 32'hFFFF_FFFF);
    beat(1'b0, 14'd4, 1'b0, 32'hFFFF_FF00);
    idle(3);
    chk("s5_err_fffe", 64'(o_err_cnt), 64'hFFFE);
    beat(1'b0, 14'd4, 1'b1, 32'hFFFF_FFFF);
    idle(3);
    chk("s5_err_sat", 64'(o_err_cnt), 64'hFFFF);
    beat(1'b1, 14'd4, 1'b1, 32'hFFFF_FFFF);
    idle(3);
    chk("s5_err_hold", 64'(o_err_cnt), 64'hFFFF);
    chk("s5_beat_cnt", 64'(o_beat_cnt), 64'd8194);
    finish_layer("s5");
    chk("s5_pass", 64'(o_pass), 64'd0);
`endif

    // Reset during RUN with a beat in flight
    pulse_start();
    beat(1'b1, 14'd7, 1'b0, 32'hFFFF_FFFF);
    idle(2);
    chk("rst_pre_ferr_valid", 64'(o_ferr_valid), 64'd1);
    set_beat(1'b1, 14'd7, 1'b1, 32'hFFFF_FFFF);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    i_wr = 1'b0;
    tick();
    rst = 1'b0;
    idle(3);
    check_zero("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
